// File: rtl/sweep_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
// Shared definitions for the frequency-sweep control stage: the sweep mode
// encoding, default window geometry and the last ROM address covered by the
// full set of windows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package sweep_pkg;

   typedef enum logic [0:0] {
      MODE_MANUAL = 1'b0,
      MODE_AUTO   = 1'b1
   } sweep_mode_e;

   localparam int DEF_SEG_LEN   = 100;
   localparam int DEF_SEG_COUNT = 40;
   localparam int DEF_ADDR_W    = 12;

   // Last address of the last window (3999 with the defaults).
   localparam int LAST_END = DEF_SEG_LEN * DEF_SEG_COUNT - 1;

endpackage : sweep_pkg

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises one asynchronous active-low key, debounces it and emits a
// single-cycle press pulse on each accepted 1->0 transition.
//
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   key_n  - raw asynchronous key, active low
//   press  - one-cycle pulse when a debounced press is accepted (registered)
//
// After reset the debouncer stays disarmed until the key has been seen
// released for DEBOUNCE_CYC consecutive cycles, so a key already held when
// reset is released never produces a press until it is released and pressed
// again.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module key_debounce #(
   parameter int DEBOUNCE_CYC = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1_r;
   logic             sync2_r;
   logic             level_r;
   logic             armed_r;
   logic             press_r;
   logic [CNT_W-1:0] cnt_r;

   // Two-flop synchroniser for the asynchronous key input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= key_n;
         sync2_r <= sync1_r;
      end
   end

   // Debounce counter, arming logic, accepted level and press pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r   <= {CNT_W{1'b0}};
         level_r <= 1'b1;
         armed_r <= 1'b0;
         press_r <= 1'b0;
      end else begin
         press_r <= 1'b0;
         if (!armed_r) begin
            // Wait for a stable release before accepting any press.
            if (!sync2_r) begin
               cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
               armed_r <= 1'b1;
               cnt_r   <= {CNT_W{1'b0}};
            end else begin
               cnt_r <= cnt_r + CNT_W'(1);
            end
         end else if (sync2_r == level_r) begin
            // Nothing pending: any partial count was a glitch.
            cnt_r <= {CNT_W{1'b0}};
         end else if (cnt_r == CNT_LAST) begin
            level_r <= sync2_r;
            cnt_r   <= {CNT_W{1'b0}};
            press_r <= ~sync2_r;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   assign press = press_r;

endmodule : key_debounce

// File: rtl/freq_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// freq_sweep_ctrl
// Front-panel control for the ROM-playback generator. Debounces the up and
// mode keys, runs the MANUAL/AUTO sweep state machine and publishes the
// current playback window plus a toggle that marks each window change.
//
// Ports:
//   clkin      - system clock
//   rst        - asynchronous active-high reset
//   key_up_n   - raw key, active low: step window up (MANUAL)
//   key_mode_n - raw key, active low: toggle MANUAL/AUTO
//   seg_start  - first ROM address of the current window
//   seg_end    - last ROM address of the current window
//   seg_idx    - current window index, 0..SEG_COUNT-1
//   sweep_mode - 0 = MANUAL, 1 = AUTO
//   upd_tgl    - toggles once per window change; a consumer in another clock
//                domain synchronises it and samples seg_start/seg_end on an
//                edge (the bus is quiet for a long time around each toggle,
//                since steps are at least a debounce period apart)
//   led_tick   - toggles every TICK_DIV cycles
//   led_mode   - mirrors sweep_mode
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module freq_sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int TICK_DIV     = 25000000,
   parameter int DEBOUNCE_CYC = 1000000,
   parameter int SEG_LEN      = DEF_SEG_LEN,
   parameter int SEG_COUNT    = DEF_SEG_COUNT,
   parameter int ADDR_W       = DEF_ADDR_W
) (
   input  logic              clkin,
   input  logic              rst,
   input  logic              key_up_n,
   input  logic              key_mode_n,
   output logic [ADDR_W-1:0] seg_start,
   output logic [ADDR_W-1:0] seg_end,
   output logic [5:0]        seg_idx,
   output logic              sweep_mode,
   output logic              upd_tgl,
   output logic              led_tick,
   output logic              led_mode
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [5:0]        IDX_LAST  = 6'(SEG_COUNT - 1);
   localparam logic [ADDR_W-1:0] SEG_STEP  = ADDR_W'(SEG_LEN);
   localparam logic [ADDR_W-1:0] END_FIRST = ADDR_W'(SEG_LEN - 1);

   sweep_mode_e       state_r;
   sweep_mode_e       state_nx_s;
   logic              up_press_s;
   logic              mode_press_s;
   logic              step_s;
   logic              enter_auto_s;
   logic              tick_s;
   logic [TICK_W-1:0] tick_cnt_r;
   logic              led_tick_r;
   logic              led_mode_r;
   logic              upd_tgl_r;
   logic [5:0]        seg_idx_r;
   logic [ADDR_W-1:0] seg_start_r;
   logic [ADDR_W-1:0] seg_end_r;

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_up (
      .clk   (clkin),
      .rst   (rst),
      .key_n (key_up_n),
      .press (up_press_s)
   );

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_mode (
      .clk   (clkin),
      .rst   (rst),
      .key_n (key_mode_n),
      .press (mode_press_s)
   );

   assign tick_s = (tick_cnt_r == TICK_LAST);

   // Next-state and step decision; the step source follows the current state,
   // so a simultaneous mode press does not change which source is used.
   always_comb begin
      state_nx_s   = state_r;
      step_s       = 1'b0;
      enter_auto_s = 1'b0;
      case (state_r)
         MODE_MANUAL: begin
            step_s = up_press_s;
            if (mode_press_s) begin
               state_nx_s   = MODE_AUTO;
               enter_auto_s = 1'b1;
            end else begin
               state_nx_s   = MODE_MANUAL;
            end
         end
         MODE_AUTO: begin
            step_s = tick_s;
            if (mode_press_s) begin
               state_nx_s = MODE_MANUAL;
            end else begin
               state_nx_s = MODE_AUTO;
            end
         end
         default: begin
            state_nx_s = MODE_MANUAL;
            step_s     = 1'b0;
         end
      endcase
   end

   // Mode state register and mode LED.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state_r    <= MODE_MANUAL;
         led_mode_r <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         led_mode_r <= (state_nx_s == MODE_AUTO);
      end
   end

   // Free-running tick divider, restarted on entry to AUTO so the first
   // automatic step lands one full period after the mode change.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         tick_cnt_r <= {TICK_W{1'b0}};
         led_tick_r <= 1'b0;
      end else begin
         if (enter_auto_s || tick_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
         end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
         end
         if (tick_s) begin
            led_tick_r <= ~led_tick_r;
         end
      end
   end

   // Window index and addresses, stepped incrementally with wrap to window 0.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         seg_idx_r   <= 6'd0;
         seg_start_r <= {ADDR_W{1'b0}};
         seg_end_r   <= END_FIRST;
         upd_tgl_r   <= 1'b0;
      end else if (step_s) begin
         upd_tgl_r <= ~upd_tgl_r;
         if (seg_idx_r == IDX_LAST) begin
            seg_idx_r   <= 6'd0;
            seg_start_r <= {ADDR_W{1'b0}};
            seg_end_r   <= END_FIRST;
         end else begin
            seg_idx_r   <= seg_idx_r + 6'd1;
            seg_start_r <= seg_start_r + SEG_STEP;
            seg_end_r   <= seg_end_r + SEG_STEP;
         end
      end
   end

   assign seg_start  = seg_start_r;
   assign seg_end    = seg_end_r;
   assign seg_idx    = seg_idx_r;
   assign sweep_mode = state_r;
   assign upd_tgl    = upd_tgl_r;
   assign led_tick   = led_tick_r;
   assign led_mode   = led_mode_r;

endmodule : freq_sweep_ctrl
